happy_scroll_ctrl: RTL and testbench



---
 rtl/happy_pkg.sv | 25 ++
 rtl/happy_tick_gen.sv | 42 ++++
 rtl/happy_scroll_ctrl.sv | 120 ++++++++++++
 tb/tb_happy_scroll_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/happy_pkg.sv
// rtl/happy_pkg.sv - shared types and constants for the HAPPY scroll display
package happy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int STEP_W = 4;
    localparam logic [STEP_W-1:0] DEFAULT_LAST_STEP = 4'd12;

    // Active-low seven-segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_H     = 7'b0001001;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_P     = 7'b0001100;
    localparam logic [6:0] GLYPH_Y     = 7'b0010001;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    function automatic logic [STEP_W-1:0] clamp_step(input logic [STEP_W-1:0] v,
                                                     input logic [STEP_W-1:0] last);
        return (v > last) ? last : v;
    endfunction

endpackage

// File: rtl/happy_tick_gen.sv
// rtl/happy_tick_gen.sv - scroll-rate prescaler producing a one-cycle tick
module happy_tick_gen
    import happy_pkg::*;
#(
    parameter int DIV = 25000000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The tick is the edge on which the count wraps, so it is combinational here
    assign tick = en && !clr && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!en || clr) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/happy_scroll_ctrl.sv
// rtl/happy_scroll_ctrl.sv - automatic step sequencer for the HAPPY scroll display
module happy_scroll_ctrl
    import happy_pkg::*;
#(
    parameter int DIV        = 25000000,
    parameter int LAST_STEP  = int'(DEFAULT_LAST_STEP),
    parameter int HOLD_TICKS = 2
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              START,
    input  logic              STOP,
    input  logic              DIR,
    input  logic              BOUNCE,
    input  logic              LOAD,
    input  logic [STEP_W-1:0] LOAD_STEP,
    output logic [STEP_W-1:0] STEP,
    output logic              TICK,
    output logic              SWEEP_DONE,
    output logic              RUNNING
);

    localparam logic [STEP_W-1:0] LAST   = STEP_W'(LAST_STEP);
    localparam logic [3:0]        HOLD_N = 4'(HOLD_TICKS);

    state_e            state_q;
    logic [STEP_W-1:0] step_q;
    logic [3:0]        hold_q;
    logic              cur_dir_q;
    logic              tick_q;
    logic              done_q;
    logic              running_q;

    logic              scroll_tick;
    logic              at_end;

    happy_tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .CLOCK_50(CLOCK_50),
        .RESET   (RESET),
        .en      (state_q != IDLE),
        .clr     (STOP | LOAD),
        .tick    (scroll_tick)
    );

    assign at_end = cur_dir_q ? (step_q == '0) : (step_q == LAST);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            step_q    <= '0;
            hold_q    <= '0;
            cur_dir_q <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            if (STOP) begin
                state_q   <= IDLE;
                hold_q    <= '0;
                running_q <= 1'b0;
                if (LOAD) begin
                    step_q <= clamp_step(LOAD_STEP, LAST);
                end
            end else if (LOAD) begin
                step_q <= clamp_step(LOAD_STEP, LAST);
                if (state_q == HOLD) begin
                    state_q <= RUN;
                    hold_q  <= '0;
                end
            end else if (START && (state_q == IDLE)) begin
                state_q   <= RUN;
                cur_dir_q <= DIR;
                running_q <= 1'b1;
            end else if (scroll_tick) begin
                case (state_q)
                    RUN: begin
                        if (at_end) begin
                            state_q <= HOLD;
                            hold_q  <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            step_q <= cur_dir_q ? (step_q - 4'd1) : (step_q + 4'd1);
                            tick_q <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if ((hold_q + 4'd1) == HOLD_N) begin
                            state_q <= RUN;
                            hold_q  <= '0;
                            tick_q  <= 1'b1;
                            if (BOUNCE) begin
                                // Step back off whichever end we are parked on
                                cur_dir_q <= ~cur_dir_q;
                                step_q    <= cur_dir_q ? 4'd1 : (LAST - 4'd1);
                            end else begin
                                cur_dir_q <= DIR;
                                step_q    <= DIR ? LAST : '0;
                            end
                        end else begin
                            hold_q <= hold_q + 4'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign STEP       = step_q;
    assign TICK       = tick_q;
    assign SWEEP_DONE = done_q;
    assign RUNNING    = running_q;

endmodule

// File: tb/tb_happy_scroll_ctrl.sv
// tb/tb_happy_scroll_ctrl.sv - scoreboard bench for happy_scroll_ctrl
module tb_happy_scroll_ctrl;

    localparam int DIV  = 4;
    localparam int HOLD = 2;
    localparam int LAST = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       dir = 1'b0;
    logic       bounce = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_step = 4'd0;
    logic [3:0] step;
    logic       tick;
    logic       done;
    logic       running;
    logic       probe = 1'b0;

    always #5 clk = ~clk;

    happy_scroll_ctrl #(
        .DIV       (DIV),
        .LAST_STEP (LAST),
        .HOLD_TICKS(HOLD)
    ) dut (
        .CLOCK_50  (clk),
        .RESET     (rst),
        .START     (start),
        .STOP      (stop),
        .DIR       (dir),
        .BOUNCE    (bounce),
        .LOAD      (load),
        .LOAD_STEP (load_step),
        .STEP      (step),
        .TICK      (tick),
        .SWEEP_DONE(done),
        .RUNNING   (running)
    );

    typedef struct {
        int         at;
        logic [3:0] step;
        bit         is_tick;
        bit         is_done;
    } ev_t;

    ev_t q[$];
    ev_t mon_e;
    int  checks = 0;
    int  fails = 0;
    int  n = 0;
    int  rst_cnt = 0;
    int  rst_seen = 0;

    // Reference model: position, direction, active/parked flags, tick phase origin
    int  m_pos = 0;
    bit  m_dir = 1'b0;
    bit  m_active = 1'b0;
    bit  m_park = 1'b0;
    int  m_hc = 0;
    int  m_t0 = 0;

    function automatic int clampv(int v);
        return (v > LAST) ? LAST : v;
    endfunction

    task automatic push_ev(int p, bit t, bit d);
        ev_t e;
        e.at = n;
        e.step = 4'(p);
        e.is_tick = t;
        e.is_done = d;
        q.push_back(e);
    endtask

    task automatic m_reset();
        m_pos = 0;
        m_dir = 1'b0;
        m_active = 1'b0;
        m_park = 1'b0;
        m_hc = 0;
        m_t0 = 0;
    endtask

    task automatic model_edge();
        if (stop) begin
            if (load) m_pos = clampv(int'(load_step));
            m_active = 1'b0;
            m_park = 1'b0;
        end else if (load) begin
            m_pos = clampv(int'(load_step));
            m_t0 = n;
            m_park = 1'b0;
        end else if (start && !m_active) begin
            m_active = 1'b1;
            m_dir = dir;
            m_t0 = n;
        end else if (m_active && ((n - m_t0) % DIV == 0)) begin
            if (!m_park) begin
                if ((m_dir && m_pos == 0) || (!m_dir && m_pos == LAST)) begin
                    m_park = 1'b1;
                    m_hc = 0;
                    push_ev(m_pos, 1'b0, 1'b1);
                end else begin
                    m_pos = m_dir ? m_pos - 1 : m_pos + 1;
                    push_ev(m_pos, 1'b1, 1'b0);
                end
            end else begin
                m_hc++;
                if (m_hc == HOLD) begin
                    m_park = 1'b0;
                    if (bounce) begin
                        m_dir = !m_dir;
                        m_pos = m_dir ? LAST - 1 : 1;
                    end else begin
                        m_dir = dir;
                        m_pos = m_dir ? LAST : 0;
                    end
                    push_ev(m_pos, 1'b1, 1'b0);
                end
            end
        end
    endtask

    always @(posedge clk) begin
        n++;
        if (rst || rst_cnt != rst_seen) begin
            rst_seen = rst_cnt;
            m_reset();
        end
        if (!rst) model_edge();
    end

    task automatic chk(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, got, exp, n);
        end
    endtask

    // Monitor: per-cycle state compare plus event scoreboard
    initial begin
        forever begin
            @(negedge clk or posedge probe);
            if (probe) begin
                chk("async_rst_step", int'(step), 0);
                chk("async_rst_tick", int'(tick), 0);
                chk("async_rst_done", int'(done), 0);
                chk("async_rst_running", int'(running), 0);
            end else if (!rst) begin
                chk("step", int'(step), m_pos);
                chk("running", int'(running), int'(m_active));
                if (tick || done) begin
                    chk("pending_events", int'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        mon_e = q.pop_front();
                        chk("ev_edge", n, mon_e.at);
                        chk("ev_step", int'(step), int'(mon_e.step));
                        chk("ev_tick", int'(tick), int'(mon_e.is_tick));
                        chk("ev_done", int'(done), int'(mon_e.is_done));
                    end
                end else if (q.size() > 0 && q[0].at <= n) begin
                    chk("missing_pulse", int'(tick | done), 1);
                    mon_e = q.pop_front();
                end
            end
        end
    end

    task automatic cycles(int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_pos(int v);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (m_active && !m_park && m_pos == v) break;
        end
    endtask

    task automatic wait_park();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (m_park) break;
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(5);

        // Wrap sweep, 0..12, hold, back to 0
        dir = 1'b0;
        bounce = 1'b0;
        pulse_start();
        cycles(80);

        // Freeze at 5, idle, resume
        wait_pos(5);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        cycles(20);
        pulse_start();
        cycles(10);

        // Ping-pong with DIR wiggling mid-sweep
        bounce = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (i % 7 == 0) dir = ~dir;
        end

        // Loads: clamp in RUN, exit HOLD, load under STOP
        wait_pos(6);
        load_step = 4'd15;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_park();
        load_step = 4'd3;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cycles(10);
        stop = 1'b1;
        load = 1'b1;
        load_step = 4'd9;
        @(negedge clk);
        stop = 1'b0;
        load = 1'b0;
        cycles(6);

        // Asynchronous reset at step 7
        bounce = 1'b0;
        dir = 1'b0;
        load_step = 4'd0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        pulse_start();
        wait_pos(7);
        #2 rst = 1'b1;
        rst_cnt++;
        #1 probe = 1'b1;
        #1 probe = 1'b0;
        rst = 1'b0;
        cycles(10);

        // Downward start from 0: immediate end of sweep
        dir = 1'b1;
        pulse_start();
        dir = 1'b0;
        cycles(90);

        // Randomized control traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            stop = ($urandom_range(0, 99) < 1);
            load = ($urandom_range(0, 99) < 2);
            start = ($urandom_range(0, 99) < 6);
            dir = 1'($urandom_range(0, 1));
            bounce = ($urandom_range(0, 3) != 0);
            load_step = 4'($urandom_range(0, 15));
        end
        stop = 1'b0;
        load = 1'b0;
        start = 1'b0;
        cycles(20);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
